pe_context_sequencer: RTL and testbench
=======================================

Name: pe_context_sequencer

Overview:
- Drives the per-cycle `configuration` word of a NormalPE-style processing element (context width 22).
- Holds a small context memory, loaded by a host write port while idle, and replays a contiguous context window (base..last, wrapping mod DEPTH) for a programmed number of iterations.
- Supports stall, then drains the PE's two-stage pipeline (context register, ALU result register) with NOP contexts before signalling done.

Parameters:
- CTX_WIDTH, 22, width of one context word; equals the PE configuration width.
- DEPTH, 16, number of context memory entries; must be a power of two.
- ADDR_W, 4, address width; ADDR_W = log2(DEPTH).
- ITER_W, 8, width of the iteration counter.
- DRAIN_CYCLES, 2, number of NOP cycles issued after the last context; must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_wr_en  in  1  context memory write strobe
- cfg_wr_addr  in  ADDR_W  write address
- cfg_wr_data  in  CTX_WIDTH  write data
- start  in  1  launch request; sampled only in IDLE
- base_addr  in  ADDR_W  first context address of the window
- last_addr  in  ADDR_W  final context address of the window (inclusive)
- iter_count  in  ITER_W  number of passes over the window
- stall  in  1  freeze sequencing; holds pc, counters and configuration
- configuration  out  CTX_WIDTH  registered context to the PE
- cfg_valid  out  1  configuration holds a program word, not NOP
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the run completes
- wr_err  out  1  one-cycle pulse: write attempted while busy, write dropped

Behaviour:
- Reset (synchronous, active-high): state=IDLE; configuration=0 (all-zero = NOP context); cfg_valid=0; busy=0; done=0; wr_err=0; pc=0; iteration and drain counters=0. Memory contents are not reset. Reset asserted mid-run aborts immediately: no done pulse, outputs take reset values at the next edge.
- Memory:
  - Write is synchronous, accepted only in IDLE.
  - A write in RUN or DRAIN is dropped, and wr_err pulses on the following cycle.
  - A write and start in the same IDLE cycle: the write commits first, so the first read sees the new data.
- IDLE:
  - start=1 with iter_count=0 → done pulses next cycle; state stays IDLE.
  - start=1 with iter_count≠0 → latch base, last and iter_count; pc=base_addr; go to RUN.
  - start is ignored outside IDLE.
- RUN, each cycle with stall=0:
  - configuration <= mem[pc]; cfg_valid <= 1.
  - If pc≠last: pc <= pc+1 mod DEPTH. If last<base, the window wraps through DEPTH-1 to 0.
  - If pc==last and iter_left>1: pc <= base; iter_left decrements.
  - If pc==last and iter_left==1: go to DRAIN; drain counter = DRAIN_CYCLES.
- Latency: start sampled at edge T → configuration=mem[base] after edge T+1. Window length L = ((last-base) mod DEPTH)+1. A run of N iterations yields exactly N·L valid cycles, excluding stalled cycles.
- Stall (RUN or DRAIN): configuration, cfg_valid, pc and all counters hold their values. Stall in IDLE has no effect.
- DRAIN, each cycle with stall=0:
  - configuration <= 0; cfg_valid <= 0; drain counter decrements.
  - The cycle the counter reaches 0: done <= 1 and state goes to IDLE.
- Outputs: busy is combinational from state. done and wr_err are registered, single-cycle pulses.
- Widths: all pc arithmetic is modulo 2^ADDR_W. iter_left is ITER_W bits and never underflows, because 0 is filtered in IDLE.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, DRAIN};
  - NOP context constant (all zeros, CTX_WIDTH);
  - context field offsets matching the PE: DataSelect [11:0], AluInst [15:12], output-select bits [21:16].
- One sub-module, pe_context_mem: DEPTH×CTX_WIDTH, one synchronous write port and one combinational read port. The sequencer registers the read data.

Test Plan:
- Write mem[0..3]=0x00001,0x01002,0x02003,0x3F004. start with base=0, last=3, iter=2 → configuration sequence 1,1002,2003,3F004,1,1002,2003,3F004 with cfg_valid=1, then 2 NOP cycles with cfg_valid=0, then done pulse; busy high from edge T through the DRAIN→IDLE edge.
- Wrap: base=14, last=1, iter=1 → configuration reads addresses 14,15,0,1, then drain and done.
- Stall: assert stall for 3 cycles while the output shows mem[2] → output holds mem[2] for 4 cycles total; total valid-cycle count is unchanged; done is delayed by exactly 3 cycles.
- iter_count=0 with start → done pulses 1 cycle later; busy and cfg_valid stay 0.
- Write during RUN to addr 0 with value 0x3FFFFF → wr_err pulse; the next run still outputs the original mem[0]. start asserted mid-run is ignored.
- rst asserted during the RUN cycle where pc=2 → next cycle configuration=0, busy=0, no done pulse. A subsequent start replays correctly from base.

Source files
------------

// File: rtl/pe_context_sequencer_pkg.sv
// pe_context_sequencer_pkg: shared types and constants for the PE context sequencer
// Holds the sequencer state encoding, the NOP context and the PE context field layout.
package pe_context_sequencer_pkg;

    localparam int CTX_WIDTH = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // All-zero context is the PE's no-operation word
    localparam logic [CTX_WIDTH-1:0] NOP_CTX = '0;

    // Context field layout as decoded by the PE
    localparam int DSEL_LSB = 0;
    localparam int DSEL_W   = 12;
    localparam int ALU_LSB  = 12;
    localparam int ALU_W    = 4;
    localparam int OSEL_LSB = 16;
    localparam int OSEL_W   = 6;

endpackage

// File: rtl/pe_context_mem.sv
// pe_context_mem: DEPTH x CTX_WIDTH context store, sync write, async read
// Ports: clk; wr_en_i/wr_addr_i/wr_data_i write port; rd_addr_i -> rd_data_o combinational read.
module pe_context_mem #(
    parameter int CTX_WIDTH = 22,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [CTX_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [CTX_WIDTH-1:0] rd_data_o
);

    logic [CTX_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk)
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pe_context_sequencer.sv
// pe_context_sequencer: replays a context window into a PE, then drains its pipeline
// Ports: clk, rst (sync, active-high); cfg_wr_* host write port (IDLE only);
// start/base_addr/last_addr/iter_count launch a run; stall freezes sequencing;
// configuration/cfg_valid drive the PE; busy = not IDLE; done and wr_err are 1-cycle pulses.
module pe_context_sequencer
    import pe_context_sequencer_pkg::*;
#(
    parameter int CTX_WIDTH    = pe_context_sequencer_pkg::CTX_WIDTH,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int ITER_W       = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_wr_en,
    input  logic [ADDR_W-1:0]    cfg_wr_addr,
    input  logic [CTX_WIDTH-1:0] cfg_wr_data,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    last_addr,
    input  logic [ITER_W-1:0]    iter_count,
    input  logic                 stall,
    output logic [CTX_WIDTH-1:0] configuration,
    output logic                 cfg_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_err
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d, base_q, base_d, last_q, last_d;
    logic [ITER_W-1:0]    iter_q, iter_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [CTX_WIDTH-1:0] cfg_q, cfg_d, rd_data;
    logic                 valid_q, valid_d, done_q, done_d, wr_err_q, wr_err_d;

    pe_context_mem #(
        .CTX_WIDTH(CTX_WIDTH),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W)
    ) u_mem (
        .clk      (clk),
        .wr_en_i  (cfg_wr_en && state_q == IDLE),
        .wr_addr_i(cfg_wr_addr),
        .wr_data_i(cfg_wr_data),
        .rd_addr_i(pc_q),
        .rd_data_o(rd_data)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        base_d   = base_q;
        last_d   = last_q;
        iter_d   = iter_q;
        drain_d  = drain_q;
        cfg_d    = cfg_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        wr_err_d = cfg_wr_en && state_q != IDLE;
        case (state_q)
            IDLE:
                if (start) begin
                    if (iter_count == '0) done_d = 1'b1;
                    else begin
                        state_d = RUN;
                        pc_d    = base_addr;
                        base_d  = base_addr;
                        last_d  = last_addr;
                        iter_d  = iter_count;
                    end
                end
            RUN:
                if (!stall) begin
                    cfg_d   = rd_data;
                    valid_d = 1'b1;
                    // pc wraps naturally mod DEPTH, so last < base windows need no special case
                    if (pc_q != last_q) pc_d = pc_q + 1'b1;
                    else if (iter_q > ITER_W'(1)) begin
                        pc_d   = base_q;
                        iter_d = iter_q - 1'b1;
                    end else begin
                        state_d = DRAIN;
                        iter_d  = '0;
                        drain_d = DRAIN_W'(DRAIN_CYCLES);
                    end
                end
            DRAIN:
                if (!stall) begin
                    cfg_d   = NOP_CTX;
                    valid_d = 1'b0;
                    drain_d = drain_q - 1'b1;
                    if (drain_q == DRAIN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            base_q   <= '0;
            last_q   <= '0;
            iter_q   <= '0;
            drain_q  <= '0;
            cfg_q    <= NOP_CTX;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            base_q   <= base_d;
            last_q   <= last_d;
            iter_q   <= iter_d;
            drain_q  <= drain_d;
            cfg_q    <= cfg_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign configuration = cfg_q;
    assign cfg_valid     = valid_q;
    assign busy          = state_q != IDLE;
    assign done          = done_q;
    assign wr_err        = wr_err_q;

endmodule

// File: tb/tb_pe_context_sequencer.sv
// tb_pe_context_sequencer: directed self-checking bench for pe_context_sequencer
module tb_pe_context_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_wr_en = 1'b0;
    logic [3:0]  cfg_wr_addr = '0;
    logic [21:0] cfg_wr_data = '0;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [3:0]  last_addr = '0;
    logic [7:0]  iter_count = '0;
    logic        stall = 1'b0;
    logic [21:0] configuration;
    logic        cfg_valid, busy, done, wr_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [21:0] cap[$];
    int done_cyc, busy_bad, nop_cnt, hold_cnt;
    logic [21:0] hold_val = 22'h02003;

    always #5 clk = ~clk;

    pe_context_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .start        (start),
        .base_addr    (base_addr),
        .last_addr    (last_addr),
        .iter_count   (iter_count),
        .stall        (stall),
        .configuration(configuration),
        .cfg_valid    (cfg_valid),
        .busy         (busy),
        .done         (done),
        .wr_err       (wr_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [21:0] d);
        cfg_wr_en = 1'b1;
        cfg_wr_addr = a;
        cfg_wr_data = d;
        tick;
        cfg_wr_en = 1'b0;
    endtask

    // Launches a run and records valid unstalled outputs until done or a cycle budget expires.
    task automatic run(input logic [3:0] b, input logic [3:0] l, input logic [7:0] it,
                       input int st_at, input int st_len);
        logic st;
        base_addr = b;
        last_addr = l;
        iter_count = it;
        start = 1'b1;
        tick;
        start = 1'b0;
        cfg_wr_en = 1'b0;
        cap.delete();
        done_cyc = -1;
        busy_bad = 0;
        nop_cnt = 0;
        hold_cnt = 0;
        st = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        for (int c = 1; c <= 100; c++) begin
            tick;
            if (!st && cfg_valid === 1'b1) cap.push_back(configuration);
            if (cfg_valid === 1'b0 && configuration === 22'h0) nop_cnt++;
            if (configuration === hold_val) hold_cnt++;
            if (busy !== (done !== 1'b1)) busy_bad++;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            st = st_len > 0 && c >= st_at && c < st_at + st_len;
            stall = st;
        end
        stall = 1'b0;
    endtask

    task automatic check_cap(input string name, input logic [21:0] exp[$]);
        n_cmp++;
        if (cap.size() != exp.size()) begin
            n_err++;
            $display("FAIL %s_len: got %0d want %0d", name, cap.size(), exp.size());
        end else
            for (int i = 0; i < exp.size(); i++) begin
                n_cmp++;
                if (cap[i] !== exp[i]) begin
                    n_err++;
                    $display("FAIL %s[%0d]: got %h want %h", name, i, cap[i], exp[i]);
                end
            end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        n_cmp++;
        if ({configuration, cfg_valid, busy, done, wr_err} !== 26'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got cfg=%h v=%b b=%b d=%b e=%b want all 0",
                     configuration, cfg_valid, busy, done, wr_err);
        end
    endtask

    task automatic test_basic;
        run(4'd0, 4'd3, 8'd2, 0, 0);
        check_cap("basic", '{22'h00001, 22'h01002, 22'h02003, 22'h3F004,
                             22'h00001, 22'h01002, 22'h02003, 22'h3F004});
        n_cmp++;
        if (done_cyc != 10) begin
            n_err++;
            $display("FAIL basic_done_cycle: got %0d want 10", done_cyc);
        end
        n_cmp++;
        if (nop_cnt != 2) begin
            n_err++;
            $display("FAIL basic_nop_cycles: got %0d want 2", nop_cnt);
        end
        n_cmp++;
        if (busy_bad != 0) begin
            n_err++;
            $display("FAIL basic_busy: got %0d bad cycles want 0", busy_bad);
        end
        tick;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_wrap;
        run(4'd14, 4'd1, 8'd1, 0, 0);
        check_cap("wrap", '{22'h0E00E, 22'h0F00F, 22'h00001, 22'h01002});
        n_cmp++;
        if (done_cyc != 6) begin
            n_err++;
            $display("FAIL wrap_done_cycle: got %0d want 6", done_cyc);
        end
    endtask

    task automatic test_stall;
        run(4'd0, 4'd3, 8'd1, 3, 3);
        check_cap("stall", '{22'h00001, 22'h01002, 22'h02003, 22'h3F004});
        n_cmp++;
        if (hold_cnt != 4) begin
            n_err++;
            $display("FAIL stall_hold: got %0d want 4", hold_cnt);
        end
        n_cmp++;
        if (done_cyc != 9) begin
            n_err++;
            $display("FAIL stall_done_cycle: got %0d want 9", done_cyc);
        end
    endtask

    task automatic test_iter_zero;
        base_addr = 4'd0;
        last_addr = 4'd3;
        iter_count = 8'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_cmp++;
        if ({done, busy, cfg_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL iter0_done: got d/b/v=%b%b%b want 100", done, busy, cfg_valid);
        end
        tick;
        n_cmp++;
        if ({done, busy, cfg_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL iter0_after: got d/b/v=%b%b%b want 000", done, busy, cfg_valid);
        end
    endtask

    task automatic test_write_busy;
        int dc;
        base_addr = 4'd0;
        last_addr = 4'd3;
        iter_count = 8'd1;
        start = 1'b1;
        tick;
        start = 1'b1;
        iter_count = 8'd3;
        cfg_wr_en = 1'b1;
        cfg_wr_addr = 4'd0;
        cfg_wr_data = 22'h3FFFFF;
        tick;
        cfg_wr_en = 1'b0;
        n_cmp++;
        if (wr_err !== 1'b1) begin
            n_err++;
            $display("FAIL wr_err_pulse: got %b want 1", wr_err);
        end
        dc = -1;
        for (int c = 2; c <= 100; c++) begin
            tick;
            if (c == 2) begin
                start = 1'b0;
                n_cmp++;
                if (wr_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL wr_err_single: got %b want 0", wr_err);
                end
            end
            if (done === 1'b1) begin
                dc = c;
                break;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (dc != 6) begin
            n_err++;
            $display("FAIL start_ignored_done: got %0d want 6", dc);
        end
        run(4'd0, 4'd0, 8'd1, 0, 0);
        check_cap("mem0_kept", '{22'h00001});
    endtask

    task automatic test_write_start;
        cfg_wr_en = 1'b1;
        cfg_wr_addr = 4'd5;
        cfg_wr_data = 22'h15A5A;
        run(4'd5, 4'd5, 8'd1, 0, 0);
        check_cap("wr_start", '{22'h15A5A});
    endtask

    task automatic test_reset_midrun;
        int dones;
        base_addr = 4'd0;
        last_addr = 4'd3;
        iter_count = 8'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        n_cmp++;
        if (configuration !== 22'h01002) begin
            n_err++;
            $display("FAIL midrun_pre: got %h want 01002", configuration);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++;
        if ({configuration, cfg_valid, busy, done} !== 25'h0) begin
            n_err++;
            $display("FAIL midrun_reset: got cfg=%h v=%b b=%b d=%b want all 0",
                     configuration, cfg_valid, busy, done);
        end
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL midrun_quiet: got %0d active cycles want 0", dones);
        end
        run(4'd0, 4'd3, 8'd1, 0, 0);
        check_cap("post_reset", '{22'h00001, 22'h01002, 22'h02003, 22'h3F004});
        n_cmp++;
        if (done_cyc != 6) begin
            n_err++;
            $display("FAIL post_reset_done: got %0d want 6", done_cyc);
        end
    endtask

    initial begin
        test_reset;
        wr(4'd0, 22'h00001);
        wr(4'd1, 22'h01002);
        wr(4'd2, 22'h02003);
        wr(4'd3, 22'h3F004);
        wr(4'd14, 22'h0E00E);
        wr(4'd15, 22'h0F00F);
        test_basic;
        test_wrap;
        test_stall;
        test_iter_zero;
        test_write_busy;
        test_write_start;
        test_reset_midrun;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
